// File: rtl/max7219_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_pkg
//  Description : Shared definitions for the MAX7219 display scheduler:
//                scheduler FSM state encoding, serializer state encoding,
//                MAX7219 register addresses and the power-up init ROM.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package max7219_pkg;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_IDLE     = 3'd1,
      ST_SEND_INT = 3'd2,
      ST_SEND_DIG = 3'd3,
      ST_WAIT_GAP = 3'd4
   } sched_state_e;

   // Serializer states
   typedef enum logic [0:0] {
      TX_IDLE  = 1'b0,
      TX_SHIFT = 1'b1
   } tx_state_e;

   // MAX7219 register addresses
   localparam logic [3:0] c_addr_noop      = 4'h0;
   localparam logic [3:0] c_addr_digit0    = 4'h1;
   localparam logic [3:0] c_addr_decode    = 4'h9;
   localparam logic [3:0] c_addr_intensity = 4'hA;
   localparam logic [3:0] c_addr_scanlim   = 4'hB;
   localparam logic [3:0] c_addr_shutdown  = 4'hC;
   localparam logic [3:0] c_addr_test      = 4'hF;

   // Index of the last init ROM entry (five entries, 0..4)
   localparam logic [2:0] c_init_last = 3'd4;

   // Build a 16-bit MAX7219 frame: {4'h0, addr, data}
   function automatic logic [15:0] make_frame(input logic [3:0] addr,
                                              input logic [7:0] data);
      return {4'h0, addr, data};
   endfunction

   // Init ROM. Entry 3 carries the currently held brightness code.
   function automatic logic [15:0] init_frame(input logic [2:0] idx,
                                              input logic [3:0] intensity);
      logic [15:0] f;
      case (idx)
         3'd0:    f = make_frame(c_addr_shutdown,  8'h01);
         3'd1:    f = make_frame(c_addr_decode,    8'h00);
         3'd2:    f = make_frame(c_addr_scanlim,   8'h07);
         3'd3:    f = make_frame(c_addr_intensity, {4'h0, intensity});
         3'd4:    f = make_frame(c_addr_test,      8'h00);
         default: f = make_frame(c_addr_noop,      8'h00);
      endcase
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/max7219_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_serial_tx
//  Description : Shifts one 16-bit frame MSB first onto the MAX7219 serial
//                pins. LOAD falls on the first frame cycle, each bit holds
//                SCLK low for SCLK_DIV cycles then high for SCLK_DIV cycles,
//                LOAD rises after the 16th bit. The inter-frame LOAD-high
//                gap is timed by the caller.
//  Ports       : i_clk, i_reset      - clock, synchronous active-high reset
//                i_start, i_frame    - start a frame (accepted when idle)
//                o_done              - high in the last frame cycle; LOAD
//                                      rises on the following edge
//                o_serial_load/dout/clk - MAX7219 LOAD, DIN, CLK
//  Revision    : 1.0 - initial release
// ============================================================================
module max7219_serial_tx
   import max7219_pkg::*;
#(
   parameter int SCLK_DIV = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [15:0] i_frame,
   output logic        o_done,
   output logic        o_serial_load,
   output logic        o_serial_dout,
   output logic        o_serial_clk
);

   localparam logic [7:0] c_div_last = 8'(SCLK_DIV - 1);

   tx_state_e   state_q, state_d;
   logic [7:0]  div_q,   div_d;     // cycles within the current half period
   logic        half_q,  half_d;    // 0: SCLK low phase, 1: SCLK high phase
   logic [3:0]  bit_q,   bit_d;     // bit index within the frame
   logic [15:0] shreg_q, shreg_d;   // remaining bits, next one at [15]
   logic        load_q,  load_d;
   logic        sclk_q,  sclk_d;
   logic        dout_q,  dout_d;
   logic        w_done;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      half_d  = half_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      load_d  = load_q;
      sclk_d  = sclk_q;
      dout_d  = dout_q;
      w_done  = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (i_start) begin
               // Registered outputs: LOAD low and bit 15 on DIN from the next cycle
               load_d  = 1'b0;
               sclk_d  = 1'b0;
               dout_d  = i_frame[15];
               shreg_d = {i_frame[14:0], 1'b0};
               bit_d   = 4'd0;
               div_d   = 8'd0;
               half_d  = 1'b0;
               state_d = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (div_q == c_div_last) begin
               div_d = 8'd0;
               if (!half_q) begin
                  sclk_d = 1'b1;
                  half_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  half_d = 1'b0;
                  if (bit_q == 4'd15) begin
                     // Frame end: the bit counter wraps only here
                     bit_d   = 4'd0;
                     load_d  = 1'b1;
                     dout_d  = 1'b0;
                     w_done  = 1'b1;
                     state_d = TX_IDLE;
                  end else begin
                     bit_d   = bit_q + 4'd1;
                     dout_d  = shreg_q[15];
                     shreg_d = {shreg_q[14:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= TX_IDLE;
         div_q   <= 8'd0;
         half_q  <= 1'b0;
         bit_q   <= 4'd0;
         shreg_q <= 16'h0000;
         load_q  <= 1'b1;
         sclk_q  <= 1'b0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         load_q  <= load_d;
         sclk_q  <= sclk_d;
         dout_q  <= dout_d;
      end
   end

   assign o_done        = w_done;
   assign o_serial_load = load_q;
   assign o_serial_dout = dout_q;
   assign o_serial_clk  = sclk_q;

endmodule
`default_nettype wire

// File: rtl/max7219_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_scheduler
//  Description : Drives a MAX7219 8-digit display. Sends the five-frame init
//                sequence after reset, then services brightness and digit
//                refresh requests. Requests are held as pending flags with
//                shadow data; arbitration happens at each frame boundary
//                with brightness ahead of digit frames.
//  Ports       : i_clk, i_reset          - clock, synchronous active-high reset
//                i_update_stb, i_digits  - new segment data (digit n = [8n+7:8n])
//                i_intensity_stb, i_intensity - new brightness code
//                o_serial_load/dout/clk  - MAX7219 LOAD, DIN, CLK
//                o_init_done             - init sequence complete
//                o_busy                  - frame in flight or request pending
//  Revision    : 1.0 - initial release
// ============================================================================
module max7219_scheduler
   import max7219_pkg::*;
#(
   parameter int SCLK_DIV = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_update_stb,
   input  logic [63:0] i_digits,
   input  logic        i_intensity_stb,
   input  logic [3:0]  i_intensity,
   output logic        o_serial_load,
   output logic        o_serial_dout,
   output logic        o_serial_clk,
   output logic        o_init_done,
   output logic        o_busy
);

   localparam logic [7:0] c_gap_last = 8'(SCLK_DIV - 1);

   sched_state_e state_q,     state_d;
   logic [2:0]   init_idx_q,  init_idx_d;
   logic         issued_q,    issued_d;     // first init frame already launched
   logic [7:0]   gap_q,       gap_d;        // LOAD-high gap cycle counter
   logic         init_done_q, init_done_d;
   logic         busy_q,      busy_d;
   logic         int_pend_q,  int_pend_d;
   logic         upd_pend_q,  upd_pend_d;
   logic [3:0]   int_reg_q,   int_reg_d;
   logic [63:0]  shadow_q,    shadow_d;
   logic [63:0]  snap_q,      snap_d;       // burst snapshot, frozen per burst
   logic [2:0]   dig_idx_q,   dig_idx_d;    // next digit to send in the burst
   logic         burst_q,     burst_d;      // a burst has digits left to send

   logic         w_start;
   logic [15:0]  w_frame;
   logic         w_tx_done;
   logic         w_arb;
   logic         w_int_take;
   logic         w_upd_take;

   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      issued_d    = issued_q;
      gap_d       = gap_q;
      init_done_d = init_done_q;
      int_reg_d   = int_reg_q;
      shadow_d    = shadow_q;
      snap_d      = snap_q;
      dig_idx_d   = dig_idx_q;
      burst_d     = burst_q;
      w_start     = 1'b0;
      w_frame     = 16'h0000;
      w_arb       = 1'b0;
      w_int_take  = 1'b0;
      w_upd_take  = 1'b0;

      // Last strobe wins
      if (i_intensity_stb) int_reg_d = i_intensity;
      if (i_update_stb)    shadow_d  = i_digits;

      case (state_q)
         ST_INIT: begin
            // Only the first init frame is launched from here; later ones
            // are launched at the end of each gap.
            if (!issued_q) begin
               w_start  = 1'b1;
               w_frame  = init_frame(init_idx_q, int_reg_q);
               issued_d = 1'b1;
            end
            if (w_tx_done) begin
               gap_d   = 8'd0;
               state_d = ST_WAIT_GAP;
            end
         end
         ST_SEND_INT, ST_SEND_DIG: begin
            if (w_tx_done) begin
               gap_d   = 8'd0;
               state_d = ST_WAIT_GAP;
            end
         end
         ST_WAIT_GAP: begin
            if (gap_q == c_gap_last) begin
               gap_d = 8'd0;
               if (!init_done_q && (init_idx_q != c_init_last)) begin
                  init_idx_d = init_idx_q + 3'd1;
                  w_start    = 1'b1;
                  w_frame    = init_frame(init_idx_q + 3'd1, int_reg_q);
                  state_d    = ST_INIT;
               end else begin
                  init_done_d = 1'b1;
                  w_arb       = 1'b1;
               end
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         ST_IDLE: w_arb = 1'b1;
         default: state_d = ST_INIT;
      endcase

      // Frame-boundary arbitration: brightness, then the running burst,
      // then a fresh burst from the shadow register.
      if (w_arb) begin
         if (int_pend_q) begin
            w_int_take = 1'b1;
            w_start    = 1'b1;
            w_frame    = make_frame(c_addr_intensity, {4'h0, int_reg_q});
            state_d    = ST_SEND_INT;
         end else if (burst_q) begin
            w_start = 1'b1;
            w_frame = make_frame(4'(dig_idx_q) + c_addr_digit0,
                                 snap_q[{dig_idx_q, 3'b000} +: 8]);
            if (dig_idx_q == 3'd7) begin
               burst_d   = 1'b0;
               dig_idx_d = 3'd0;
            end else begin
               dig_idx_d = dig_idx_q + 3'd1;
            end
            state_d = ST_SEND_DIG;
         end else if (upd_pend_q) begin
            w_upd_take = 1'b1;
            w_start    = 1'b1;
            snap_d     = shadow_q;
            w_frame    = make_frame(c_addr_digit0, shadow_q[7:0]);
            dig_idx_d  = 3'd1;
            burst_d    = 1'b1;
            state_d    = ST_SEND_DIG;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // A strobe landing on the consuming cycle re-arms its flag
   assign int_pend_d = i_intensity_stb | (int_pend_q & ~w_int_take);
   assign upd_pend_d = i_update_stb    | (upd_pend_q & ~w_upd_take);
   assign busy_d     = (state_d != ST_IDLE) | int_pend_d | upd_pend_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_INIT;
         init_idx_q  <= 3'd0;
         issued_q    <= 1'b0;
         gap_q       <= 8'd0;
         init_done_q <= 1'b0;
         busy_q      <= 1'b0;
         int_pend_q  <= 1'b0;
         upd_pend_q  <= 1'b0;
         int_reg_q   <= 4'h0;
         shadow_q    <= 64'h0;
         snap_q      <= 64'h0;
         dig_idx_q   <= 3'd0;
         burst_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_idx_q  <= init_idx_d;
         issued_q    <= issued_d;
         gap_q       <= gap_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         int_pend_q  <= int_pend_d;
         upd_pend_q  <= upd_pend_d;
         int_reg_q   <= int_reg_d;
         shadow_q    <= shadow_d;
         snap_q      <= snap_d;
         dig_idx_q   <= dig_idx_d;
         burst_q     <= burst_d;
      end
   end

   max7219_serial_tx #(
      .SCLK_DIV (SCLK_DIV)
   ) u_tx (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_start       (w_start),
      .i_frame       (w_frame),
      .o_done        (w_tx_done),
      .o_serial_load (o_serial_load),
      .o_serial_dout (o_serial_dout),
      .o_serial_clk  (o_serial_clk)
   );

   assign o_init_done = init_done_q;
   assign o_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max7219_scheduler
//  Description : Directed self-checking bench. Two instances share stimulus:
//                dut (SCLK_DIV=2) and dut_d1 (SCLK_DIV=1). A serial decoder
//                per instance rebuilds frames on each LOAD rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max7219_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ustb, istb;
   logic [63:0] digs;
   logic [3:0]  inten;
   logic        ld0, do0, sc0, dn0, bz0;
   logic        ld1, do1, sc1, dn1, bz1;

   max7219_scheduler #(.SCLK_DIV(2)) dut (
      .i_clk(clk), .i_reset(rst), .i_update_stb(ustb), .i_digits(digs),
      .i_intensity_stb(istb), .i_intensity(inten),
      .o_serial_load(ld0), .o_serial_dout(do0), .o_serial_clk(sc0),
      .o_init_done(dn0), .o_busy(bz0));

   max7219_scheduler #(.SCLK_DIV(1)) dut_d1 (
      .i_clk(clk), .i_reset(rst), .i_update_stb(ustb), .i_digits(digs),
      .i_intensity_stb(istb), .i_intensity(inten),
      .o_serial_load(ld1), .o_serial_dout(do1), .o_serial_clk(sc1),
      .o_init_done(dn1), .o_busy(bz1));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- serial decoders ----------------
   logic [15:0] fq0[$], fq1[$], eq[$];
   int          tq0[$], tq1[$];
   logic        pl0 = 1'b1, ps0 = 1'b0, pl1 = 1'b1, ps1 = 1'b0;
   logic [15:0] sh0 = 16'h0, sh1 = 16'h0;
   int          bits0 = 0, bits1 = 0, partial0 = 0;
   int          last1 = 0, per_min1 = 999, per_max1 = 0;

   always @(negedge clk) begin
      if (pl0 === 1'b1 && ld0 === 1'b0) begin bits0 = 0; sh0 = 16'h0; end
      if (ld0 === 1'b0 && ps0 === 1'b0 && sc0 === 1'b1) begin
         sh0 = {sh0[14:0], do0};
         bits0++;
      end
      if (pl0 === 1'b0 && ld0 === 1'b1) begin
         if (bits0 == 16) begin fq0.push_back(sh0); tq0.push_back(cyc); end
         else partial0++;
      end
      pl0 = ld0;
      ps0 = sc0;
   end

   always @(negedge clk) begin
      if (pl1 === 1'b1 && ld1 === 1'b0) begin bits1 = 0; sh1 = 16'h0; end
      if (ld1 === 1'b0 && ps1 === 1'b0 && sc1 === 1'b1) begin
         if (bits1 >= 1) begin
            if (cyc - last1 < per_min1) per_min1 = cyc - last1;
            if (cyc - last1 > per_max1) per_max1 = cyc - last1;
         end
         last1 = cyc;
         sh1 = {sh1[14:0], do1};
         bits1++;
      end
      if (pl1 === 1'b0 && ld1 === 1'b1 && bits1 == 16) begin
         fq1.push_back(sh1);
         tq1.push_back(cyc);
      end
      pl1 = ld1;
      ps1 = sc1;
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic timeout(input string tag);
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout at cycle %0d", tag, cyc);
   endtask

   function automatic logic [63:0] mk(input logic [7:0] base);
      logic [63:0] d;
      for (int n = 0; n < 8; n++) d[8*n +: 8] = base + 8'(n);
      return d;
   endfunction

   function automatic logic [15:0] dfr(input int n, input logic [7:0] base);
      return {4'h0, 4'(n + 1), base + 8'(n)};
   endfunction

   task automatic push_burst(input logic [7:0] base);
      for (int n = 0; n < 8; n++) eq.push_back(dfr(n, base));
   endtask

   task automatic push_init();
      eq.push_back(16'h0C01); eq.push_back(16'h0900); eq.push_back(16'h0B07);
      eq.push_back(16'h0A00); eq.push_back(16'h0F00);
   endtask

   task automatic clear_q();
      fq0.delete(); tq0.delete(); fq1.delete(); tq1.delete(); eq.delete();
   endtask

   task automatic pulse_upd(input logic [7:0] base);
      digs = mk(base);
      ustb = 1'b1;
      tick();
      ustb = 1'b0;
   endtask

   task automatic pulse_int(input logic [3:0] v);
      inten = v;
      istb  = 1'b1;
      tick();
      istb  = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      repeat (2) tick();
      while ((bz0 || bz1) && k < limit) begin tick(); k++; end
      if (k >= limit) timeout("wait_idle");
   endtask

   task automatic wait_frames(input int n, input int limit);
      int k = 0;
      while (fq0.size() < n && k < limit) begin tick(); k++; end
      if (k >= limit) timeout("wait_frames");
   endtask

   task automatic wait_init(input int rel, input string tag);
      int k = 0;
      while (!dn0 && k < 400) begin tick(); k++; end
      if (k >= 400) timeout(tag);
      else check({tag, "_latency"}, 32'(cyc - rel), 32'd330);
   endtask

   task automatic cmp_frames(input bit sel, input string tag);
      int n;
      n = sel ? fq1.size() : fq0.size();
      check({tag, "_count"}, 32'(n), 32'(eq.size()));
      for (int i = 0; i < eq.size() && i < n; i++)
         check($sformatf("%s[%0d]", tag, i), 32'(sel ? fq1[i] : fq0[i]), 32'(eq[i]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rel;
      int k;
      rst = 1'b1; ustb = 1'b0; istb = 1'b0; digs = 64'h0; inten = 4'h0;
      repeat (4) tick();

      // Reset levels
      check("rst_load", 32'(ld0), 32'd1);
      check("rst_sclk", 32'(sc0), 32'd0);
      check("rst_dout", 32'(do0), 32'd0);
      check("rst_init_done", 32'(dn0), 32'd0);
      check("rst_busy", 32'(bz0), 32'd0);

      // Init sequence after release
      rst = 1'b0;
      tick();
      rel = cyc;
      check("rel_busy", 32'(bz0), 32'd1);
      check("rel_load_low", 32'(ld0), 32'd0);
      wait_init(rel, "init");
      push_init();
      cmp_frames(1'b0, "init");
      check("init_busy_end", 32'(bz0), 32'd0);
      wait_idle(500);

      // Plain refresh burst
      clear_q();
      pulse_upd(8'h10);
      wait_idle(1200);
      push_burst(8'h10);
      cmp_frames(1'b0, "burst");
      if (tq0.size() >= 8)
         for (int i = 1; i < 8; i++)
            check($sformatf("burst_gap[%0d]", i), 32'(tq0[i] - tq0[i-1]), 32'd66);
      check("burst_busy_end", 32'(bz0), 32'd0);

      // Brightness inserted during the third digit frame
      clear_q();
      pulse_upd(8'h20);
      wait_frames(2, 300);
      repeat (10) tick();
      pulse_int(4'h7);
      wait_idle(1500);
      for (int n = 0; n < 3; n++) eq.push_back(dfr(n, 8'h20));
      eq.push_back(16'h0A07);
      for (int n = 3; n < 8; n++) eq.push_back(dfr(n, 8'h20));
      cmp_frames(1'b0, "insert");

      // Two updates mid-burst: original burst completes, then one with the last data
      clear_q();
      pulse_upd(8'h30);
      wait_frames(1, 200);
      repeat (10) tick();
      pulse_upd(8'h50);
      repeat (70) tick();
      pulse_upd(8'h60);
      wait_idle(2500);
      push_burst(8'h30);
      push_burst(8'h60);
      cmp_frames(1'b0, "coalesce");

      // Simultaneous strobes in idle, both divider settings
      clear_q();
      per_min1 = 999;
      per_max1 = 0;
      digs  = mk(8'h70);
      inten = 4'h3;
      ustb  = 1'b1;
      istb  = 1'b1;
      tick();
      ustb  = 1'b0;
      istb  = 1'b0;
      wait_idle(1500);
      eq.push_back(16'h0A03);
      push_burst(8'h70);
      cmp_frames(1'b0, "simul");
      cmp_frames(1'b1, "simul_d1");
      check("d1_sclk_period_min", 32'(per_min1), 32'd2);
      check("d1_sclk_period_max", 32'(per_max1), 32'd2);
      if (tq1.size() >= 2) check("d1_frame_gap", 32'(tq1[1] - tq1[0]), 32'd33);

      // Reset during bit 9 of a digit frame
      clear_q();
      pulse_upd(8'h80);
      wait_frames(1, 200);
      k = 0;
      while (!(bits0 == 9 && sc0 == 1'b0 && ld0 == 1'b0) && k < 200) begin tick(); k++; end
      if (k >= 200) timeout("bit9");
      rst = 1'b1;
      tick();
      check("midrst_load", 32'(ld0), 32'd1);
      check("midrst_sclk", 32'(sc0), 32'd0);
      check("midrst_dout", 32'(do0), 32'd0);
      tick();
      fq0.delete();
      tq0.delete();
      partial0 = 0;
      tick();
      check("midrst_busy", 32'(bz0), 32'd0);
      check("midrst_init_done", 32'(dn0), 32'd0);
      rst = 1'b0;
      tick();
      rel = cyc;
      check("rerel_busy", 32'(bz0), 32'd1);
      wait_init(rel, "reinit");
      eq.delete();
      push_init();
      cmp_frames(1'b0, "reinit");
      check("reinit_partial", 32'(partial0), 32'd0);
      repeat (3) tick();
      check("reinit_busy_end", 32'(bz0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
